// File: rtl/pipe_pkg.sv
// Shared definitions for the pipeline MEM stage.
//   DW          : data / address width
//   RW          : register-number width
//   mem_state_e : MEM-stage handshake FSM encoding (IDLE=0, WAIT=1)
package pipe_pkg;

    localparam int DW = 32;
    localparam int RW = 5;

    // Wide enough for any MAX_WAIT in 1..255
    localparam int CNT_W = 8;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_WAIT = 1'b1
    } mem_state_e;

endpackage

// File: rtl/pipemwreg.sv
// MEM/WB pipeline register.
// load_i=1 captures the instruction leaving MEM. load_i=0 inserts a bubble:
// the write enables clear and the data fields hold their previous values.
//   clock, resetn : clock and async active-low reset
//   load_i        : capture (1) or bubble (0)
//   *_i           : next MEM/WB contents
//   *_o           : MEM/WB register outputs toward writeback
module pipemwreg
    import pipe_pkg::*;
#(
    parameter int DW = pipe_pkg::DW,
    parameter int RW = pipe_pkg::RW
) (
    input  logic          clock,
    input  logic          resetn,
    input  logic          load_i,
    input  logic          wreg_i,
    input  logic          m2reg_i,
    input  logic [DW-1:0] mo_i,
    input  logic [DW-1:0] alu_i,
    input  logic [RW-1:0] rn_i,
    output logic          wreg_o,
    output logic          m2reg_o,
    output logic [DW-1:0] mo_o,
    output logic [DW-1:0] alu_o,
    output logic [RW-1:0] rn_o
);

    logic          wreg_q, m2reg_q;
    logic [DW-1:0] mo_q, alu_q;
    logic [RW-1:0] rn_q;

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            wreg_q  <= 1'b0;
            m2reg_q <= 1'b0;
            mo_q    <= '0;
            alu_q   <= '0;
            rn_q    <= '0;
        end else if (load_i) begin
            wreg_q  <= wreg_i;
            m2reg_q <= m2reg_i;
            mo_q    <= mo_i;
            alu_q   <= alu_i;
            rn_q    <= rn_i;
        end else begin
            // Bubble: nothing is written back, data fields keep their value
            wreg_q  <= 1'b0;
            m2reg_q <= 1'b0;
        end
    end

    assign wreg_o  = wreg_q;
    assign m2reg_o = m2reg_q;
    assign mo_o    = mo_q;
    assign alu_o   = alu_q;
    assign rn_o    = rn_q;

endmodule

// File: rtl/pipemem_stage.sv
// MEM stage: issues data-memory accesses with a req/ack handshake, stalls
// the upstream pipeline while an access is outstanding, aborts an access
// after MAX_WAIT wait cycles without ack, and owns the MEM/WB register.
//
// state | meaning
// ------+-------------------------------------------------------------
// IDLE  | no access outstanding; a memop issues req combinationally
// WAIT  | access outstanding, cnt_q counts wait cycles since issue
//
// Ports:
//   clock, resetn                  : clock, async active-low reset
//   mwreg, mm2reg, mwmem, malu, mb, mrn : EX/MEM register inputs
//   dmem_req/we/addr/wdata         : data-memory request side
//   dmem_ack, dmem_rdata           : data-memory response side
//   mstall                         : freeze upstream stages this cycle
//   merr                           : one-cycle pulse on timeout abort
//   wwreg, wm2reg, wmo, walu, wrn  : MEM/WB register outputs
module pipemem_stage
    import pipe_pkg::*;
#(
    parameter int DW       = pipe_pkg::DW,
    parameter int RW       = pipe_pkg::RW,
    parameter int MAX_WAIT = 15
) (
    input  logic          clock,
    input  logic          resetn,
    input  logic          mwreg,
    input  logic          mm2reg,
    input  logic          mwmem,
    input  logic [DW-1:0] malu,
    input  logic [DW-1:0] mb,
    input  logic [RW-1:0] mrn,
    output logic          dmem_req,
    output logic          dmem_we,
    output logic [DW-1:0] dmem_addr,
    output logic [DW-1:0] dmem_wdata,
    input  logic          dmem_ack,
    input  logic [DW-1:0] dmem_rdata,
    output logic          mstall,
    output logic          merr,
    output logic          wwreg,
    output logic          wm2reg,
    output logic [DW-1:0] wmo,
    output logic [DW-1:0] walu,
    output logic [RW-1:0] wrn
);

    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(MAX_WAIT);

    mem_state_e        state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              merr_q;

    logic              memop;
    logic              done;
    logic              abort;
    logic              wb_load;
    logic [DW-1:0]     wb_mo;

    assign memop = mm2reg | mwmem;

    // Request is gated by resetn so it drops the instant reset asserts,
    // even while the frozen EX/MEM still presents a memory instruction.
    assign dmem_req   = resetn & (((state_q == ST_IDLE) & memop) | (state_q == ST_WAIT));
    assign dmem_we    = mwmem & ~mm2reg;
    assign dmem_addr  = malu;
    assign dmem_wdata = mb;

    assign done   = dmem_req & dmem_ack;
    assign abort  = (state_q == ST_WAIT) & (cnt_q == CNT_MAX) & ~dmem_ack;
    assign mstall = dmem_req & ~dmem_ack & ~abort;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        unique case (state_q)
            ST_IDLE: begin
                if (memop && !dmem_ack) begin
                    state_d = ST_WAIT;
                    cnt_d   = CNT_W'(1);
                end
            end
            ST_WAIT: begin
                if (dmem_ack || abort) begin
                    state_d = ST_IDLE;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            default: begin
                state_d = ST_IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            merr_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            merr_q  <= abort;
        end
    end

    assign merr = merr_q;

    // Retire into MEM/WB when there is nothing to wait for or the access
    // just completed; stalls and aborts both become bubbles.
    assign wb_load = ~memop | done;
    assign wb_mo   = mm2reg ? dmem_rdata : '0;

    pipemwreg #(
        .DW (DW),
        .RW (RW)
    ) u_mwreg (
        .clock   (clock),
        .resetn  (resetn),
        .load_i  (wb_load),
        .wreg_i  (mwreg),
        .m2reg_i (mm2reg),
        .mo_i    (wb_mo),
        .alu_i   (malu),
        .rn_i    (mrn),
        .wreg_o  (wwreg),
        .m2reg_o (wm2reg),
        .mo_o    (wmo),
        .alu_o   (walu),
        .rn_o    (wrn)
    );

endmodule

// File: doc/pipemem_stage.md
Name: pipemem_stage

Overview:
- MEM stage of the five-stage pipeline, directly downstream of the EX/MEM register.
- Consumes the EX/MEM outputs (mwreg, mm2reg, mwmem, malu, mb, mrn).
- Drives a variable-latency data-memory port with a req/ack handshake and stalls upstream stages while an access is outstanding.
- Owns the MEM/WB register that feeds writeback.

Parameters:
- DW, 32, data and address width.
- RW, 5, register-number width.
- MAX_WAIT, 15, number of wait cycles without ack before an access is aborted (1..255).

Ports:
- clock  in  1  system clock, all state on rising edge
- resetn  in  1  asynchronous active-low reset; one clock, no other reset
- mwreg  in  1  EX/MEM: register write enable
- mm2reg  in  1  EX/MEM: load (result from memory)
- mwmem  in  1  EX/MEM: store
- malu  in  DW  EX/MEM: ALU result / effective address
- mb  in  DW  EX/MEM: store data
- mrn  in  RW  EX/MEM: destination register
- dmem_req  out  1  memory request, held until ack or abort
- dmem_we  out  1  1 = write, 0 = read; valid while dmem_req=1
- dmem_addr  out  DW  byte address = malu
- dmem_wdata  out  DW  = mb
- dmem_ack  in  1  access complete; dmem_rdata valid same cycle for reads
- dmem_rdata  in  DW  read data
- mstall  out  1  freeze PC, IF/ID, ID/EX, EX/MEM this cycle
- merr  out  1  one-cycle pulse on timeout abort
- wwreg  out  1  MEM/WB: register write enable
- wm2reg  out  1  MEM/WB: select memory data
- wmo  out  DW  MEM/WB: loaded data
- walu  out  DW  MEM/WB: ALU result
- wrn  out  RW  MEM/WB: destination register

Behaviour:
- Reset (resetn=0, asynchronous):
  - State goes to IDLE; wait counter cleared.
  - Outputs: dmem_req=0, merr=0, wwreg=0, wm2reg=0, wmo=0, walu=0, wrn=0.
  - A reset mid-access abandons the access; the memory must tolerate req dropping without ack.
- memop = mm2reg | mwmem. mm2reg=1 and mwmem=1 together is illegal; the load takes precedence and dmem_we=0.
- dmem_req = (state==IDLE & memop) | (state==WAIT). Combinational, so the request is issued in the same cycle the instruction sits in MEM.
- dmem_we = mwmem & ~mm2reg; dmem_addr = malu; dmem_wdata = mb. All stable while stalled, because EX/MEM is frozen.
- done = dmem_req & dmem_ack; abort = (state==WAIT) & (cnt==MAX_WAIT) & ~dmem_ack.
- mstall = dmem_req & ~dmem_ack & ~abort (combinational).
- FSM:
  - IDLE: memop & ~dmem_ack -> WAIT with cnt=1; otherwise stay in IDLE. Zero-wait ack completes in IDLE.
  - WAIT: dmem_ack -> IDLE; abort -> IDLE; otherwise cnt++.
- MEM/WB update on each clock edge:
  - Non-memop or done: wwreg<=mwreg, wm2reg<=mm2reg, walu<=malu, wrn<=mrn, wmo<=(mm2reg ? dmem_rdata : 0).
  - Stalled (mstall=1): bubble. wwreg<=0, wm2reg<=0; walu, wmo, wrn hold.
  - Abort: bubble as above, plus merr<=1 for one cycle. The instruction retires without writeback.
  - merr<=0 in all other cycles.
- Latency:
  - Non-memory instruction: 1 cycle, MEM to W.
  - Memory instruction: 1 + number of wait cycles before ack.
- dmem_ack while dmem_req=0 is ignored.

Decomposition:
- Shared package (pipe_pkg): DW/RW constants and FSM state encoding (IDLE=0, WAIT=1).
- One natural sub-module: pipemwreg, the MEM/WB register with load and bubble controls and the same async active-low reset.
- FSM, counter and handshake logic stay in pipemem_stage.

Test Plan:
- Reset mid-WAIT: assert resetn=0 -> dmem_req=0 immediately, all W outputs 0; after release, a fresh load reissues the request.
- ALU op (mwreg=1, mm2reg=0, mwmem=0, malu=0x1234, mrn=5) -> next edge: wwreg=1, walu=0x1234, wrn=5, wm2reg=0; mstall=0, dmem_req=0 throughout.
- Load with zero-wait ack (mm2reg=1, mwreg=1, malu=0x40, dmem_ack=1, rdata=0xDEADBEEF same cycle) -> mstall=0; next edge: wm2reg=1, wmo=0xDEADBEEF, wrn=mrn.
- Store with 3 wait cycles (mwmem=1, malu=0x80, mb=0xCAFE) -> dmem_req=1, we=1, addr=0x80, wdata=0xCAFE held 4 cycles; mstall=1 for 3; wwreg=0 bubbles; completes on ack, then IDLE.
- Timeout (MAX_WAIT=15, no ack on a load) -> mstall released after 15 WAIT cycles; merr pulses once; wwreg=0; dmem_req=0 the next cycle.
- Back-to-back loads, ack after 2 cycles each -> two completions with correct wmo values, and no lost or duplicated request.
